// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-enabled word-aligned load/store unit; LSU_MISALIGN_EN enables split word-crossing accesses
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
`ifdef LSU_MISALIGN_EN
  logic [31:0] lo_q;
`endif

  // Access size in bytes from the low func3 bits.
  function automatic logic [2:0] acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

  // Unshifted byte-lane mask for the access size.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // True when the access spills into the next word.
  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    crosses = ({1'b0, off} + acc_size(f3)) > 3'd4;
  endfunction

  // Encodings with no legal meaning; unsigned variants do not exist for stores.
  function automatic logic illegal(input logic we, input logic [2:0] f3);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Align the addressed bytes to bit 0 and sign/zero-extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [63:0] raw, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = 32'(raw >> {off, 3'b000});
    case (f3)
      F3_B:    load_ext = {{24{s[7]}}, s[7:0]};
      F3_H:    load_ext = {{16{s[15]}}, s[15:0]};
      F3_W:    load_ext = s;
      F3_BU:   load_ext = {24'b0, s[7:0]};
      F3_HU:   load_ext = {16'b0, s[15:0]};
      default: load_ext = 32'b0;
    endcase
  endfunction

  logic       req_fault;
  logic [1:0] lat_off;
  logic [3:0] lat_mask;

  assign lat_off  = addr_q[1:0];
  assign lat_mask = lane_mask(func3_q);

`ifdef LSU_MISALIGN_EN
  logic        lat_cross;
  logic [7:0]  be_field;
  logic [63:0] wd_field;
  assign req_fault = illegal(req_we, req_func3);
  assign lat_cross = crosses(func3_q, lat_off);
  assign be_field  = {4'b0, lat_mask} << lat_off;
  assign wd_field  = {32'b0, wdata_q} << {lat_off, 3'b000};
`else
  logic        req_cross;
  logic [3:0]  be_field;
  logic [31:0] wd_field;
  assign req_cross = crosses(req_func3, req_addr[1:0]);
  assign req_fault = illegal(req_we, req_func3) || req_cross;
  assign be_field  = lat_mask << lat_off;
  assign wd_field  = wdata_q << {lat_off, 3'b000};
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

  // Memory port driven only in the access states; quiet and zero otherwise.
  always_comb begin
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    mem_be    = 4'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      ACC0: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be_field[3:0];
        mem_wdata = wd_field[31:0];
        mem_we    = we_q;
        mem_re    = !we_q;
      end
`ifdef LSU_MISALIGN_EN
      ACC1: begin
        mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
        mem_be    = be_field[7:4];
        mem_wdata = wd_field[63:32];
        mem_we    = we_q;
        mem_re    = !we_q;
      end
`endif
      default: ;
    endcase
  end

  // Request FSM: latch, access one or two words, emit a single response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      func3_q      <= 3'b0;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_fault_q <= 1'b0;
`ifdef LSU_MISALIGN_EN
      lo_q         <= 32'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            func3_q <= req_func3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_fault) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'b0;
            end else begin
              state_q <= ACC0;
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGN_EN
          if (lat_cross) begin
            lo_q    <= we_q ? 32'b0 : mem_rdata;
            state_q <= ACC1;
          end else
`endif
          begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= we_q ? 32'b0 : load_ext({32'b0, mem_rdata}, lat_off, func3_q);
          end
        end
`ifdef LSU_MISALIGN_EN
        ACC1: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= we_q ? 32'b0 : load_ext({mem_rdata, lo_q}, lat_off, func3_q);
        end
`endif
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:255] = '{default: 32'b0};
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  int checks = 0;
  int errors = 0;
  int lat;
  int strobes;
  logic [31:0] rd;
  logic        flt;
  logic [31:0] lg_addr [0:7];
  logic [31:0] lg_wdata [0:7];
  logic [3:0]  lg_be [0:7];
  logic        lg_we [0:7];
  logic        lg_re [0:7];
  logic        seen;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    `CHK("ready_before_req", req_ready, 1'b1)
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
    lat = 99; strobes = 0; rd = 32'hxxxxxxxx; flt = 1'bx;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      lg_addr[c] = mem_addr; lg_wdata[c] = mem_wdata; lg_be[c] = mem_be;
      lg_we[c] = mem_we; lg_re[c] = mem_re;
      if (mem_we || mem_re) strobes++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
    checks++;
    if (lat == 99) begin
      errors++;
      $error("FAIL resp_seen: no resp_valid within 7 cycles of accept");
    end
    @(negedge clk);
    `CHK("resp_one_pulse", resp_valid, 1'b0)
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $error("FAIL rst_ready observed=%0h expected=1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $error("FAIL rst_resp_valid observed=%0h expected=0", resp_valid); end
    checks++;
    if (resp_rdata !== 32'h0) begin errors++; $error("FAIL rst_resp_rdata observed=%0h expected=0", resp_rdata); end
    checks++;
    if (resp_fault !== 1'b0) begin errors++; $error("FAIL rst_resp_fault observed=%0h expected=0", resp_fault); end
    checks++;
    if (mem_we !== 1'b0) begin errors++; $error("FAIL rst_mem_we observed=%0h expected=0", mem_we); end
    checks++;
    if (mem_re !== 1'b0) begin errors++; $error("FAIL rst_mem_re observed=%0h expected=0", mem_re); end
    checks++;
    if (mem_be !== 4'h0) begin errors++; $error("FAIL rst_mem_be observed=%0h expected=0", mem_be); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $error("FAIL rst_mem_addr observed=%0h expected=0", mem_addr); end
    req_valid = 1'b1; req_func3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    `CHK("rst_no_accept", mem_re, 1'b0)
    req_valid = 1'b0; req_func3 = 3'b0; req_addr = 32'b0;
    rst_n = 1'b1;

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    `CHK("sw_lat", lat, 2)
    `CHK("sw_addr", lg_addr[1], 32'h10)
    `CHK("sw_be", lg_be[1], 4'hF)
    `CHK("sw_we", lg_we[1], 1'b1)
    `CHK("sw_wdata", lg_wdata[1], 32'hDEADBEEF)
    `CHK("sw_fault", flt, 1'b0)
    `CHK("sw_rdata", rd, 32'h0)

    issue(1'b0, 3'b010, 32'h10, 32'h0);
    `CHK("lw_lat", lat, 2)
    `CHK("lw_re", lg_re[1], 1'b1)
    `CHK("lw_be", lg_be[1], 4'hF)
    `CHK("lw_rdata", rd, 32'hDEADBEEF)

    issue(1'b1, 3'b000, 32'h23, 32'h80);
    `CHK("sb_addr", lg_addr[1], 32'h20)
    `CHK("sb_be", lg_be[1], 4'b1000)
    `CHK("sb_wdata", lg_wdata[1], 32'h80000000)
    issue(1'b0, 3'b000, 32'h23, 32'h0);
    `CHK("lb_rdata", rd, 32'hFFFFFF80)
    issue(1'b0, 3'b100, 32'h23, 32'h0);
    `CHK("lbu_rdata", rd, 32'h00000080)

    issue(1'b1, 3'b001, 32'h22, 32'hABCD9234);
    `CHK("sh_be", lg_be[1], 4'b1100)
    `CHK("sh_wdata", lg_wdata[1], 32'h92340000)
    issue(1'b0, 3'b001, 32'h22, 32'h0);
    `CHK("lh_rdata", rd, 32'hFFFF9234)
    issue(1'b0, 3'b101, 32'h22, 32'h0);
    `CHK("lhu_rdata", rd, 32'h00009234)
    issue(1'b0, 3'b001, 32'h21, 32'h0);
    `CHK("lh_off1_lat", lat, 2)
    `CHK("lh_off1_rdata", rd, 32'h00003400)

`ifdef LSU_MISALIGN_EN
    issue(1'b1, 3'b010, 32'h0E, 32'h11223344);
    `CHK("xsw_lat", lat, 3)
    `CHK("xsw_addr0", lg_addr[1], 32'h0C)
    `CHK("xsw_be0", lg_be[1], 4'b1100)
    `CHK("xsw_wdata0", lg_wdata[1], 32'h33440000)
    `CHK("xsw_addr1", lg_addr[2], 32'h10)
    `CHK("xsw_be1", lg_be[2], 4'b0011)
    `CHK("xsw_wdata1", lg_wdata[2], 32'h00001122)
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    `CHK("xlw_lat", lat, 3)
    `CHK("xlw_fault", flt, 1'b0)
    `CHK("xlw_rdata", rd, 32'h11223344)
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    `CHK("wrap_addr0", lg_addr[1], 32'hFFFFFFFC)
    `CHK("wrap_be0", lg_be[1], 4'b1000)
    `CHK("wrap_addr1", lg_addr[2], 32'h00000000)
    `CHK("wrap_be1", lg_be[2], 4'b0001)
    `CHK("wrap_rdata", rd, 32'h0)
`else
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    `CHK("xlw_lat", lat, 1)
    `CHK("xlw_fault", flt, 1'b1)
    `CHK("xlw_rdata", rd, 32'h0)
    `CHK("xlw_strobes", strobes, 0)
    issue(1'b1, 3'b010, 32'h0E, 32'h11223344);
    `CHK("xsw_fault", flt, 1'b1)
    `CHK("xsw_strobes", strobes, 0)
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    `CHK("wrap_fault", flt, 1'b1)
    `CHK("wrap_lat", lat, 1)
`endif

    issue(1'b0, 3'b011, 32'h10, 32'h0);
    `CHK("f3_011_fault", flt, 1'b1)
    `CHK("f3_011_lat", lat, 1)
    `CHK("f3_011_strobes", strobes, 0)
    issue(1'b1, 3'b100, 32'h10, 32'h5A);
    `CHK("st_1xx_fault", flt, 1'b1)
    `CHK("st_1xx_strobes", strobes, 0)

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_func3 = 3'b0; req_addr = 32'b0;
    @(negedge clk);
    `CHK("midrst_in_acc0", mem_re, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("midrst_ready", req_ready, 1'b1)
    `CHK("midrst_mem_re", mem_re, 1'b0)
    `CHK("midrst_mem_we", mem_we, 1'b0)
    `CHK("midrst_mem_be", mem_be, 4'h0)
    `CHK("midrst_resp_valid", resp_valid, 1'b0)
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    `CHK("midrst_no_resp", seen, 1'b0)

    issue(1'b0, 3'b010, 32'h10, 32'h0);
`ifdef LSU_MISALIGN_EN
    `CHK("post_rst_lw", rd, 32'hDEAD1122)
`else
    `CHK("post_rst_lw", rd, 32'hDEADBEEF)
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the CPU's memory stage and the byte-addressed data memory. Accepts one load or store per handshake, converts it into word-aligned, byte-enabled memory accesses, and returns extended load data. Word-crossing accesses are split into two consecutive word accesses, with the second access compiled in or out by macro. Read data from memory is combinational; writes commit on the clock edge.

## Interface
- No parameters; address and data widths fixed at 32.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  access type, shared F3_* encodings: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  sign/zero-extended load data; 0 for stores and faults
- resp_fault  out  1  valid with resp_valid; illegal func3, or misaligned without the macro
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-positioned store data
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  32  combinational word read of mem_addr

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. On req_valid && rst_n, latch we, func3, addr, wdata, then go to ACC0. If func3 is illegal (011, 110, 111), or for stores 1xx, go straight to RESP with fault=1.
- Size: 1, 2 or 4 bytes. off = addr[1:0]. Access crosses when off+size > 4.
- Lane math: mask = 1/3/F, shifted left by off into an 8-bit field. Shifted data = {32'b0, wdata} << 8*off into a 64-bit field.
- ACC0: mem_addr = {addr[31:2],2'b00}, mem_be = field[3:0], mem_wdata = shifted[31:0], mem_we = we, mem_re = !we. For a load, capture mem_rdata into lo. If the access crosses, go to ACC1; otherwise go to RESP.
- ACC1: mem_addr = ACC0 address + 4, wrapping modulo 2^32 (0xFFFFFFFC goes to 0x0). mem_be = field[7:4], mem_wdata = shifted[63:32]. For a load, capture mem_rdata into hi. Go to RESP.
- Load result: raw = ({hi,lo} >> 8*off) truncated to size. LB/LH sign-extend from bit 7/15; LBU/LHU/LW zero-extend. hi is treated as 0 when the access does not cross.
- RESP: resp_valid=1 with registered rdata and fault, then go to IDLE.
- mem_we, mem_re and mem_be are 0 in IDLE and RESP, so the memory never sees a stray strobe.
- Disabled lanes are don't-care in mem_wdata but driven deterministically: zero-filled per the shift.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, all mem_* outputs 0, latched registers 0. No request is accepted while rst_n=0.
- Aligned or non-crossing access: accept at edge N, ACC0 during cycle N+1, resp_valid during cycle N+2, next accept possible at edge N+3.
- Crossing access: ACC0 at N+1, ACC1 at N+2, resp_valid at N+3.
- Fault without memory access: resp_valid during cycle N+1.
- Store data is written at the rising edge ending each ACC cycle.
- Load data is sampled at the same edge from the combinational mem_rdata.
- Request inputs are ignored outside IDLE, and no back-to-back accept occurs during RESP.
- Reset mid-operation: immediate return to IDLE and all outputs to reset values. If reset lands after ACC0 of a crossing store, the first word stays written and the second word is lost; this is accepted behaviour.

## Configuration
- LSU_MISALIGN_EN defined: crossing accesses split into ACC0+ACC1 as above, and resp_fault=0 for them.
- LSU_MISALIGN_EN undefined: ACC1 and the hi register are removed. A crossing access goes IDLE→RESP with resp_fault=1, resp_rdata=0, and no memory strobe. Non-crossing misaligned accesses (for example LB at off=3, or LH at off=1) still complete normally.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → mem_be=F, mem_addr=0x10; resp_rdata=0xDEADBEEF; resp_valid exactly 2 cycles after each accept.
- SB 0x80 @0x23, then LB @0x23 → store has mem_addr=0x20, mem_be=1000, mem_wdata[31:24]=0x80; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- LH @0x22 holding bytes 0x34,0x92 → resp_rdata=0xFFFF9234; LHU → 0x00009234.
- With macro defined, SW 0x11223344 @0x0E → ACC0 at 0x0C with be=1100, ACC1 at 0x10 with be=0011; LW @0x0E returns 0x11223344, resp_valid 3 cycles after accept.
- Without macro, LW @0x0E → resp_fault=1 one cycle after accept, no mem_we/mem_re pulse; func3=011 gives a fault in both builds.
- Wrap and reset: a crossing LH @0xFFFFFFFF issues ACC1 at 0x00000000. In a separate run, assert rst_n low during ACC0 → next cycle state is IDLE, req_ready=1, mem_we=0, resp_valid never pulses.
